// File: rtl/coherent_cycle_averager_if.sv
// coherent_cycle_averager_if
// Output stream from the cycle averager to the readout/FIFO stage.
//   out_data  : averaged sample (DATA_W bits)
//   out_valid : out_data holds a valid point
//   out_ready : downstream accepts the point this cycle
//   out_last  : marks the last point of the averaged cycle
// master = averager (source), slave = readout stage (sink).
interface coherent_cycle_averager_if #(
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/coherent_cycle_averager.sv
// coherent_cycle_averager
// Arms on start, aligns phase index 0 to a zero_cross pulse, accumulates
// 2^log2_ciclos consecutive signal cycles point-by-point, then streams the
// averaged single-cycle waveform out over a valid/ready interface.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : sample-valid qualifier for data
//   start            : single-cycle measurement request
//   ptos_x_ciclo     : points per cycle (1..MAX_PTS), latched at start
//   log2_ciclos      : log2 of averaged cycles (0..MAX_LOG2), latched at start
//   data             : input sample
//   zero_cross       : phase alignment pulse
//   out_if           : averaged output stream (master)
//   busy             : measurement in progress
//   done             : pulse after the final output handshake
//   cfg_err          : pulse when a start request is rejected
module coherent_cycle_averager #(
  parameter int DATA_W   = 14,
  parameter int MAX_PTS  = 256,
  parameter int ADDR_W   = 8,
  parameter int MAX_LOG2 = 8,
  parameter int ACC_W    = 22
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      start,
  input  logic [15:0]               ptos_x_ciclo,
  input  logic [3:0]                log2_ciclos,
  input  logic [DATA_W-1:0]         data,
  input  logic                      zero_cross,
  coherent_cycle_averager_if.master out_if,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int PASS_W = MAX_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DUMP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptos_m1;
  logic [3:0]          log2_l;
  logic [ADDR_W-1:0]   idx;
  logic [PASS_W-1:0]   pass_cnt;
  logic [ADDR_W-1:0]   oidx;
  logic [ACC_W-1:0]    acc [MAX_PTS];

  logic [ACC_W-1:0]    acc_rd;
  logic [ACC_W-1:0]    wr_val;
  logic [ACC_W-1:0]    first_val;
  logic [ACC_W-1:0]    next_val;
  logic [ADDR_W-1:0]   next_oidx;
  logic [PASS_W-1:0]   last_pass;
  logic                step;
  logic                idx_wrap;
  logic                final_step;
  logic                cfg_ok;

  // The arming sample is treated as an ordinary accumulation step at idx 0 of
  // pass 0, so ARM and ACCUM share the same write/advance logic.
  // With a single point per cycle the first output is the value being written
  // on the final step, so it must bypass the array.
  always_comb begin
    acc_rd     = acc[idx];
    wr_val     = (pass_cnt == '0) ? ACC_W'(data) : acc_rd + ACC_W'(data);
    step       = enable && (((state == ARM) && zero_cross) || (state == ACCUM));
    idx_wrap   = (idx == ptos_m1);
    last_pass  = (PASS_W'(1) << log2_l) - PASS_W'(1);
    final_step = step && idx_wrap && (pass_cnt == last_pass);
    first_val  = (ptos_m1 == '0) ? wr_val : acc[0];
    next_oidx  = oidx + ADDR_W'(1);
    next_val   = acc[next_oidx];
    cfg_ok     = (ptos_x_ciclo != 16'd0) && (ptos_x_ciclo <= 16'(MAX_PTS)) &&
                 (log2_ciclos <= 4'(MAX_LOG2));
  end

  // Accumulator array: synchronous write, no reset (first pass overwrites).
  always_ff @(posedge clk) begin
    if (step) begin
      acc[idx] <= wr_val;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      ptos_m1          <= '0;
      log2_l           <= '0;
      idx              <= '0;
      pass_cnt         <= '0;
      oidx             <= '0;
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              ptos_m1  <= ADDR_W'(ptos_x_ciclo - 16'd1);
              log2_l   <= log2_ciclos;
              idx      <= '0;
              pass_cnt <= '0;
              busy     <= 1'b1;
              state    <= ARM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ARM, ACCUM: begin
          if (step) begin
            if (final_step) begin
              oidx             <= '0;
              out_if.out_valid <= 1'b1;
              out_if.out_data  <= DATA_W'(first_val >> log2_l);
              out_if.out_last  <= (ptos_m1 == '0);
              state            <= DUMP;
            end else begin
              if (idx_wrap) begin
                idx      <= '0;
                pass_cnt <= pass_cnt + PASS_W'(1);
              end else begin
                idx <= idx + ADDR_W'(1);
              end
              state <= ACCUM;
            end
          end
        end
        DUMP: begin
          if (out_if.out_valid && out_if.out_ready) begin
            if (out_if.out_last) begin
              out_if.out_valid <= 1'b0;
              out_if.out_last  <= 1'b0;
              done             <= 1'b1;
              busy             <= 1'b0;
              state            <= IDLE;
            end else begin
              oidx            <= next_oidx;
              out_if.out_data <= DATA_W'(next_val >> log2_l);
              out_if.out_last <= (next_oidx == ptos_m1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_cycle_averager.sv
// tb_coherent_cycle_averager
// Self-checking bench for coherent_cycle_averager. A behavioural model keeps
// the collected samples of a measurement in a queue and computes the averaged
// waveform by direct summation; a compare process checks DUT outputs against
// it every cycle, and directed runs are also pinned to hand-computed results.
module tb_coherent_cycle_averager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [15:0] ptos_in;
  logic [3:0]  log2_in;
  logic [13:0] data;
  logic        zero_cross;
  logic        busy;
  logic        done;
  logic        cfg_err;

  coherent_cycle_averager_if #(.DATA_W(14)) oif ();

  coherent_cycle_averager dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .start        (start),
    .ptos_x_ciclo (ptos_in),
    .log2_ciclos  (log2_in),
    .data         (data),
    .zero_cross   (zero_cross),
    .out_if       (oif),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;

  // Model state
  bit meas_active = 0;
  bit armed = 0;
  bit dumping = 0;
  bit end_pending = 0;
  bit exp_done = 0;
  bit exp_cfg_err = 0;
  int m_ptos = 0;
  int m_log2 = 0;
  int samples[$];
  int exp_q[$];
  int model_result[$];
  int got_q[$];
  int lit_q[$];
  int done_cnt = 0;
  int last_cnt = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic zc, input logic [13:0] d, input logic st);
    @(posedge clk);
    #1;
    enable     = en;
    zero_cross = zc;
    data       = d;
    start      = st;
    cyc++;
    case (ready_mode)
      0:       oif.out_ready = 1'b1;
      1:       oif.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: oif.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  function automatic void modelClear();
    meas_active = 0; armed = 0; dumping = 0; end_pending = 0;
    exp_done = 0; exp_cfg_err = 0;
    samples.delete();
    exp_q.delete();
  endfunction

  // Averaged waveform: point i is the floor mean of sample i of every pass.
  function automatic void modelBuild();
    longint sum;
    exp_q.delete();
    model_result.delete();
    for (int i = 0; i < m_ptos; i++) begin
      sum = 0;
      for (int p = 0; p < (1 << m_log2); p++) sum += samples[p * m_ptos + i];
      exp_q.push_back(int'(sum >> m_log2));
      model_result.push_back(int'(sum >> m_log2));
    end
  endfunction

  // Model advance on each clock edge, using the inputs the DUT sees.
  always @(posedge clk) begin
    bit was_active;
    if (!reset_n) begin
      modelClear();
    end else begin
      exp_done = 0;
      exp_cfg_err = 0;
      was_active = meas_active;
      if (end_pending) begin
        meas_active = 0; dumping = 0; end_pending = 0; exp_done = 1;
      end
      if (!was_active && start) begin
        if (ptos_in >= 1 && ptos_in <= 256 && log2_in <= 8) begin
          meas_active = 1; armed = 0;
          m_ptos = int'(ptos_in); m_log2 = int'(log2_in);
          samples.delete();
        end else begin
          exp_cfg_err = 1;
        end
      end else if (was_active && meas_active && !dumping && enable && (armed || zero_cross)) begin
        armed = 1;
        samples.push_back(int'(data));
        if (samples.size() == (m_ptos << m_log2)) begin
          modelBuild();
          dumping = 1;
        end
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      modelClear();
      checkOutput("rst_out_valid", oif.out_valid, 0);
      checkOutput("rst_out_last", oif.out_last, 0);
      checkOutput("rst_out_data", oif.out_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_cfg_err", cfg_err, 0);
    end else begin
      checkOutput("busy", busy, meas_active);
      checkOutput("done", done, exp_done);
      checkOutput("cfg_err", cfg_err, exp_cfg_err);
      checkOutput("out_valid", oif.out_valid, dumping);
      if (done) done_cnt++;
      if (oif.out_valid && dumping && exp_q.size() > 0) begin
        checkOutput("out_data", oif.out_data, exp_q[0]);
        checkOutput("out_last", oif.out_last, exp_q.size() == 1);
        if (oif.out_ready) begin
          got_q.push_back(int'(oif.out_data));
          if (oif.out_last) last_cnt++;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) end_pending = 1;
        end
      end
    end
  end

  function automatic logic [13:0] sampleVal(input int dmode, input int ptos, input int k);
    int t0[4] = '{10, 20, 30, 40};
    int t1[4] = '{13, 21, 30, 45};
    case (dmode)
      0:       return 14'(k % ptos);
      1:       return (k < 4) ? 14'(t0[k % 4]) : 14'(t1[k % 4]);
      2:       return 14'd16383;
      default: return 14'($urandom_range(0, 16383));
    endcase
  endfunction

  // Start a measurement and feed exactly ptos*2^lg enabled samples after arming.
  task automatic feedRun(input int ptos, input int lg, input int dmode, input int rmode,
                         input bit en_rand, input bit gap5, input bit midstart, input bit extra_zc);
    int total = ptos << lg;
    int k;
    bit en;
    bit gapped = 0;
    got_q.delete();
    ready_mode = rmode;
    ptos_in = 16'(ptos);
    log2_in = 4'(lg);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    ptos_in = 16'($urandom_range(0, 400));
    log2_in = 4'($urandom_range(0, 15));
    applyStimulus(1, 0, 14'($urandom_range(1, 16383)), 0);
    applyStimulus(0, 1, 14'h3fff, 0);
    applyStimulus(1, 0, 14'($urandom_range(1, 16383)), 0);
    applyStimulus(1, 1, sampleVal(dmode, ptos, 0), 0);
    k = 1;
    while (k < total) begin
      if (gap5 && !gapped && k == total / 2) begin
        repeat (5) applyStimulus(0, 0, 14'($urandom_range(0, 16383)), 0);
        gapped = 1;
      end
      en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (midstart && k == 2) ptos_in = 16'd7;
      applyStimulus(en, extra_zc && (k == ptos + 1),
                    en ? sampleVal(dmode, ptos, k) : 14'($urandom_range(0, 16383)),
                    midstart && (k == 2));
      if (en) k++;
    end
  endtask

  task automatic runMeasurement(input int ptos, input int lg, input int dmode, input int rmode,
                                input bit en_rand, input bit gap5, input bit midstart, input bit extra_zc);
    int done0 = done_cnt;
    int last0 = last_cnt;
    int budget = 0;
    feedRun(ptos, lg, dmode, rmode, en_rand, gap5, midstart, extra_zc);
    while (done_cnt == done0 && budget < 4000) begin
      applyStimulus(0, 0, 0, 0);
      budget++;
    end
    if (done_cnt == done0) checkOutput("done_timeout", 0, 1);
    checkOutput("hs_count", got_q.size(), ptos);
    checkOutput("done_count", done_cnt - done0, 1);
    checkOutput("last_count", last_cnt - last0, 1);
  endtask

  task automatic checkLiterals(input string name);
    checkOutput({name, "_len"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size(); i++) begin
      checkOutput({name, "_dut"}, (i < got_q.size()) ? got_q[i] : -1, lit_q[i]);
      checkOutput({name, "_model"}, (i < model_result.size()) ? model_result[i] : -1, lit_q[i]);
    end
  endtask

  task automatic badStart(input int p, input int l);
    ptos_in = 16'(p);
    log2_in = 4'(l);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("cfg_err_pulse", cfg_err, 1);
    checkOutput("cfg_err_busy", busy, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("cfg_err_clear", cfg_err, 0);
  endtask

  initial begin
    int budget;
    reset_n = 1'b0;
    enable = 0; start = 0; zero_cross = 0; data = 0;
    ptos_in = 0; log2_in = 0;
    oif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_data", oif.out_data, 0);
    checkOutput("reset_busy", busy, 0);
    reset_n = 1'b1;

    // Ramp 0..7 over 4 passes averages back to the ramp.
    runMeasurement(8, 2, 0, 0, 0, 0, 0, 0);
    lit_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    checkLiterals("ramp");

    // Two passes with floor division.
    runMeasurement(4, 1, 1, 0, 0, 0, 0, 0);
    lit_q = '{11, 20, 30, 42};
    checkLiterals("floor");

    // Full-scale over 256 passes must not overflow.
    runMeasurement(4, 8, 2, 0, 0, 0, 0, 0);
    lit_q = '{16383, 16383, 16383, 16383};
    checkLiterals("fullscale");

    // Stalled output stream with 1,0,0,1 ready pattern.
    runMeasurement(8, 2, 0, 1, 0, 0, 0, 0);
    lit_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    checkLiterals("stall");

    // Rejected configurations.
    badStart(0, 2);
    badStart(300, 2);
    badStart(8, 9);

    // Start during accumulation is ignored.
    runMeasurement(4, 1, 1, 0, 0, 0, 1, 0);
    lit_q = '{11, 20, 30, 42};
    checkLiterals("midstart");

    // Enable gap plus stray zero_cross during accumulation.
    runMeasurement(8, 2, 0, 2, 0, 1, 0, 1);
    lit_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    checkLiterals("gap_zc");

    // Boundary point counts.
    runMeasurement(1, 0, 3, 2, 1, 0, 0, 0);
    runMeasurement(1, 3, 3, 2, 1, 0, 0, 0);
    runMeasurement(256, 0, 3, 0, 0, 0, 0, 0);

    // Reset in the middle of the output stream.
    feedRun(6, 1, 3, 1, 0, 0, 0, 0);
    budget = 0;
    while (!oif.out_valid && budget < 50) begin
      applyStimulus(0, 0, 0, 0);
      budget++;
    end
    checkOutput("dump_reached", oif.out_valid, 1);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", oif.out_valid, 0);
    checkOutput("async_rst_data", oif.out_data, 0);
    checkOutput("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    runMeasurement(5, 2, 3, 2, 1, 0, 0, 0);

    // Randomized measurements.
    for (int r = 0; r < 10; r++) begin
      runMeasurement($urandom_range(1, 24), $urandom_range(0, 3), 3, 2, 1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) applyStimulus(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coherent_cycle_averager.md
Name: coherent_cycle_averager

Overview:
Downstream consumer of the zero-cross detector's `zero_cross` pulse. On a start request it arms and waits for a `zero_cross` pulse. It then accumulates 2^log2_ciclos consecutive cycles of `data` point-by-point into an internal accumulator array, with phase index 0 aligned to that pulse. Afterwards it streams out the averaged single-cycle waveform over a valid/ready interface to the readout/FIFO stage.

Parameters:
DATA_W, 14, sample width (unsigned, matches ADC path)
MAX_PTS, 256, accumulator array depth; max supported points per cycle
ADDR_W, 8, log2(MAX_PTS)
MAX_LOG2, 8, largest accepted log2_ciclos
ACC_W, 22, accumulator width = DATA_W + MAX_LOG2 (no overflow possible)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
enable  in  1  sample-valid qualifier; `data` is consumed only when high
start  in  1  single-cycle request to begin a measurement
ptos_x_ciclo  in  16  points per signal cycle, latched at start
log2_ciclos  in  4  number of averaged cycles = 2^log2_ciclos, latched at start
data  in  DATA_W  input sample
zero_cross  in  1  single-cycle pulse from the zero-cross detector
out_data  out  DATA_W  averaged sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_last  out  1  high with the last point (index ptos-1)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final output handshake
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
Reset values:
- out_data=0, out_valid=0, out_last=0, busy=0, done=0, cfg_err=0.
- State is IDLE; all counters are 0.
- Accumulator array contents are don't-care, because the first pass overwrites them.

IDLE:
- start=1 with 1 <= ptos_x_ciclo <= MAX_PTS and log2_ciclos <= MAX_LOG2 latches both values and moves to ARM.
- Any other start pulse: cfg_err pulses for one cycle and the state stays IDLE.

ARM:
- Waits for zero_cross=1 AND enable=1.
- The sample present in that same cycle is index 0 of pass 0, and it is written. Next state is ACCUM with idx=1.
- A zero_cross arriving with enable=0 is ignored.

ACCUM:
- Each cycle with enable=1:
  - Pass 0: acc[idx] <= zero-extended data (write, no add).
  - Later passes: acc[idx] <= acc[idx] + data.
  - idx wraps at ptos-1 to 0 and increments the pass counter.
- enable=0 freezes idx, the pass counter and the array.
- zero_cross pulses are ignored in this state. The index is free-running once aligned, so no re-sync occurs mid-measurement.
- The array uses combinational read and synchronous write. The read-modify-write is single-cycle, so no hazard arises.
- After the write of index ptos-1 in pass 2^log2-1, the next state is DUMP with oidx=0.
- Special case log2=0: a single pass, and samples are passed through.

DUMP:
- out_valid=1 starting the first cycle in DUMP, i.e. one cycle after the final accumulation write.
- out_data = acc[oidx] >> log2, truncating (floor). The output is registered.
- out_last = (oidx == ptos-1).
- On out_valid && out_ready: oidx increments and the next value is presented the following cycle. Back-to-back throughput is one point per clock.
- While out_ready=0: out_data, out_valid and out_last hold stable.
- Handshake of the last point: out_valid=0, then done pulses for one cycle, then the state returns to IDLE.

General rules:
- start while busy=1 is ignored; no cfg_err is raised.
- reset_n low at any time returns to IDLE with the reset output values. A partial measurement is discarded.
- ptos_x_ciclo and log2_ciclos changing after start have no effect.
- Latency from start to first out_valid is T_arm + ptos * 2^log2 enabled cycles + 1 cycle. Here T_arm is the wait for the first zero_cross with enable high.

Test Plan:
1. ptos=8, log2=2, data ramp 0..7 repeating, zero_cross when data=0 -> 8 outputs 0,1,...,7; out_last only on 7; done pulses once; busy falls the same cycle done rises.
2. ptos=4, log2=1, pass values {10,20,30,40} then {13,21,30,45} -> outputs 11,20,30,42 (floor).
3. ptos=4, log2=8, data constant 16383 for 1024 samples -> all outputs 16383 (no overflow).
4. out_ready toggled 1,0,0,1 pattern during DUMP -> out_data/out_last stable while stalled; no point lost or duplicated; exactly ptos handshakes.
5. start with ptos=0, then with ptos=300, then with log2=9 -> cfg_err pulses each time, busy stays 0. start during ACCUM -> ignored, and the result equals the undisturbed run.
6. enable low for 5 cycles mid-ACCUM plus an extra zero_cross during ACCUM -> results identical to the uninterrupted run. reset_n low mid-DUMP -> out_valid=0 immediately; next start runs cleanly.
